// File: rtl/prio_write_support_if.sv
// Write-side bundle between the upstream item source and prio_write_support.
// The slave view is the write-support block; the master view is the source/readout side.
interface prio_write_support_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 36
);
   logic              start;
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              wr_en;
   logic [ADDR_W:0]   wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] item_count;
   logic              count_valid;
   logic              rd_page;
   logic              overflow;

   modport master (
      output start, din, din_valid,
      input  wr_en, wr_addr, wr_data, item_count, count_valid, rd_page, overflow
   );

   modport slave (
      input  start, din, din_valid,
      output wr_en, wr_addr, wr_data, item_count, count_valid, rd_page, overflow
   );
endinterface

// File: rtl/prio_write_support.sv
// Ping-pong page writer: stores each crossing's items at sequential addresses of the
// current page and, at every crossing boundary, publishes the closed page's item count,
// page select and overflow flag to the readout side.
module prio_write_support #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 36
) (
   input logic               clk,
   input logic               reset,
   prio_write_support_if.slave bus
);

   typedef enum logic {IDLE, FILL} state_t;

   localparam logic [ADDR_W-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic              wr_page_q, wr_page_d;
   logic [ADDR_W-1:0] wr_cntr_q, wr_cntr_d;
   logic              ovf_sticky_q, ovf_sticky_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [ADDR_W-1:0] item_count_q, item_count_d;
   logic              count_valid_q, count_valid_d;
   logic              rd_page_q, rd_page_d;
   logic              overflow_q, overflow_d;

   logic [ADDR_W-1:0] cntr_eff;
   logic              page_eff;
   logic              accept;

   // State and datapath registers; reset overrides every input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         wr_page_q     <= 1'b0;
         wr_cntr_q     <= '0;
         ovf_sticky_q  <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         item_count_q  <= '0;
         count_valid_q <= 1'b0;
         rd_page_q     <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_page_q     <= wr_page_d;
         wr_cntr_q     <= wr_cntr_d;
         ovf_sticky_q  <= ovf_sticky_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         item_count_q  <= item_count_d;
         count_valid_q <= count_valid_d;
         rd_page_q     <= rd_page_d;
         overflow_q    <= overflow_d;
      end
   end

   // Next state: the first boundary opens a crossing; only reset closes it again.
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE && bus.start)
         state_d = FILL;
   end

   // Outputs and datapath next values.
   always_comb begin
      wr_page_d     = wr_page_q;
      wr_cntr_d     = wr_cntr_q;
      ovf_sticky_d  = ovf_sticky_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      item_count_d  = item_count_q;
      count_valid_d = 1'b0;
      rd_page_d     = rd_page_q;
      overflow_d    = overflow_q;
      cntr_eff      = wr_cntr_q;
      page_eff      = wr_page_q;

      // A coincident item belongs to the new crossing, so the boundary is applied
      // first and the write below uses the post-boundary page and counter.
      if (bus.start) begin
         cntr_eff  = '0;
         wr_cntr_d = '0;
         if (state_q == FILL) begin
            item_count_d  = wr_cntr_q;
            overflow_d    = ovf_sticky_q;
            rd_page_d     = wr_page_q;
            wr_page_d     = ~wr_page_q;
            page_eff      = ~wr_page_q;
            ovf_sticky_d  = 1'b0;
            count_valid_d = 1'b1;
         end
      end

      accept = bus.din_valid && (state_q == FILL || bus.start);

      if (accept) begin
         if (cntr_eff != CNT_MAX) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {page_eff, cntr_eff};
            wr_data_d = bus.din;
            wr_cntr_d = cntr_eff + ADDR_W'(1);
         end else begin
            ovf_sticky_d = 1'b1;
         end
      end
   end

   assign bus.wr_en       = wr_en_q;
   assign bus.wr_addr     = wr_addr_q;
   assign bus.wr_data     = wr_data_q;
   assign bus.item_count  = item_count_q;
   assign bus.count_valid = count_valid_q;
   assign bus.rd_page     = rd_page_q;
   assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_prio_write_support.sv
// Directed bench for prio_write_support: expected writes and count pulses are queued
// with their due cycle when stimulus is driven and popped when the DUT produces them.
module tb_prio_write_support;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 36;

   typedef struct {
      logic [AW:0]   addr;
      logic [DW-1:0] data;
      int            due;
   } wr_exp_t;

   typedef struct {
      logic [AW-1:0] cnt;
      logic          page;
      logic          ovf;
      int            due;
   } cnt_exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   wr_exp_t  wq[$];
   cnt_exp_t cq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   prio_write_support_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   prio_write_support #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic st, input logic dv, input logic [DW-1:0] d);
      @(negedge clk);
      bus.start     = st;
      bus.din_valid = dv;
      bus.din       = d;
   endtask

   task automatic item(input logic [DW-1:0] d, input logic [AW:0] addr);
      wr_exp_t e;
      drive(1'b0, 1'b1, d);
      e.addr = addr; e.data = d; e.due = cyc + 1;
      wq.push_back(e);
   endtask

   task automatic drop(input logic [DW-1:0] d);
      drive(1'b0, 1'b1, d);
   endtask

   task automatic close(input logic [AW-1:0] cnt, input logic page, input logic ovf);
      cnt_exp_t c;
      drive(1'b1, 1'b0, '0);
      c.cnt = cnt; c.page = page; c.ovf = ovf; c.due = cyc + 1;
      cq.push_back(c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_wr_en"},       64'(bus.wr_en),       64'd0);
      check({tag, "_wr_addr"},     64'(bus.wr_addr),     64'd0);
      check({tag, "_wr_data"},     64'(bus.wr_data),     64'd0);
      check({tag, "_item_count"},  64'(bus.item_count),  64'd0);
      check({tag, "_count_valid"}, 64'(bus.count_valid), 64'd0);
      check({tag, "_rd_page"},     64'(bus.rd_page),     64'd0);
      check({tag, "_overflow"},    64'(bus.overflow),    64'd0);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_writes_outstanding"}, 64'(wq.size()), 64'd0);
      check({tag, "_counts_outstanding"}, 64'(cq.size()), 64'd0);
   endtask

   // Output monitor: every write / count pulse must match the head of its queue.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bus.wr_en === 1'b1) begin
            check("write_was_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
               wr_exp_t e;
               e = wq.pop_front();
               check("write_cycle", 64'(cyc),         64'(e.due));
               check("write_addr",  64'(bus.wr_addr), 64'(e.addr));
               check("write_data",  64'(bus.wr_data), 64'(e.data));
            end
         end
         if (bus.count_valid === 1'b1) begin
            check("pulse_was_expected", 64'(cq.size() != 0), 64'd1);
            if (cq.size() != 0) begin
               cnt_exp_t c;
               c = cq.pop_front();
               check("pulse_cycle",    64'(cyc),            64'(c.due));
               check("pulse_count",    64'(bus.item_count), 64'(c.cnt));
               check("pulse_rd_page",  64'(bus.rd_page),    64'(c.page));
               check("pulse_overflow", 64'(bus.overflow),   64'(c.ovf));
            end
         end
      end
   end

   initial begin
      wr_exp_t e;
      bus.start     = 1'b0;
      bus.din_valid = 1'b0;
      bus.din       = '0;
      reset         = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_zero("reset");

      // Items before the first boundary are ignored; the first boundary gives no pulse.
      drop(36'h0AA);
      drop(36'h0BB);
      drop(36'h0CC);
      close_idle: begin
         drive(1'b1, 1'b0, '0);
      end
      idle(3);
      check_drained("idle_start");

      // Five items on page 0, then close.
      for (int i = 1; i <= 5; i++) item(DW'(i), 7'(i - 1));
      close(6'd5, 1'b0, 1'b0);
      idle(2);
      check_drained("five_items");

      // 70 items on page 1: 63 stored, 7 dropped.
      for (int i = 0; i < 70; i++) begin
         if (i < 63) item(36'h100 + DW'(i), {1'b1, 6'(i)});
         else        drop(36'h100 + DW'(i));
      end
      close(6'd63, 1'b1, 1'b1);
      item(36'h201, 7'h00);
      item(36'h202, 7'h01);
      close(6'd2, 1'b0, 1'b0);
      idle(2);
      check_drained("overflow");

      // Boundary coincident with an item mid-crossing.
      item(36'h301, 7'h40);
      item(36'h302, 7'h41);
      item(36'h303, 7'h42);
      drive(1'b1, 1'b1, 36'h3AB);
      begin
         cnt_exp_t c;
         c.cnt = 6'd3; c.page = 1'b1; c.ovf = 1'b0; c.due = cyc + 1;
         cq.push_back(c);
         e.addr = 7'h00; e.data = 36'h3AB; e.due = cyc + 1;
         wq.push_back(e);
      end
      idle(1);
      close(6'd1, 1'b0, 1'b0);
      idle(2);
      check_drained("coincident");

      // Back-to-back boundaries: second closes an empty page.
      for (int i = 0; i < 4; i++) item(36'h400 + DW'(i), {1'b1, 6'(i)});
      close(6'd4, 1'b1, 1'b0);
      close(6'd0, 1'b0, 1'b0);
      idle(2);
      check_drained("back_to_back");

      // Reset in the middle of a burst cancels the next write and returns to IDLE.
      item(36'h501, 7'h40);
      item(36'h502, 7'h41);
      @(negedge clk);
      reset         = 1'b1;
      bus.din_valid = 1'b1;
      bus.din       = 36'h503;
      @(negedge clk);
      reset   = 1'b0;
      bus.din = 36'h504;
      check("reset_cancels_write", 64'(bus.wr_en), 64'd0);
      drop(36'h505);
      idle(1);
      check_zero("after_reset");
      check_drained("reset_burst");

      // First boundary after reset with a coincident item writes {0,0}.
      drive(1'b1, 1'b1, 36'h5A5);
      e.addr = 7'h00; e.data = 36'h5A5; e.due = cyc + 1;
      wq.push_back(e);
      idle(1);
      close(6'd1, 1'b0, 1'b0);
      idle(3);
      check_drained("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
